// File: rtl/main_fsm.sv
// main_fsm -- multicycle control FSM for the RV64I core.
//
// Sequences each instruction through fetch, decode, execute, memory and
// writeback. It drives the datapath mux selects, the write enables, the memory
// request handshake and the coarse alu_op class consumed by alu_decoder.
//
// Optional feature macro: RV64_W_EN
//   defined   : opcodes 0111011 / 0011011 (RV64 W-type) execute with alu_op 011
//   undefined : those opcodes trap, and alu_op never takes the value 011
//
// Ports:
//   i_clk         core clock, rising edge
//   i_arst_n      synchronous active-low reset; also forces all outputs to 0
//   i_op          opcode field of the instruction register
//   i_mem_done    completion of the current memory request
//   o_alu_op      000 add, 001 sub, 010 I/R type, 011 I/R W-type
//   o_alu_src_1   00 PC, 01 old PC, 10 rs1
//   o_alu_src_2   00 rs2, 01 immediate, 10 constant 4
//   o_result_src  00 ALUOut, 01 memory data, 10 ALU result, 11 immediate
//   o_addr_src    memory address: 0 PC, 1 result bus
//   o_mem_req     memory request, held until i_mem_done
//   o_mem_we      write qualifier for o_mem_req
//   o_instr_we    instruction register load
//   o_pc_update   unconditional PC load
//   o_branch      conditional PC load (qualified by the datapath)
//   o_reg_we      register file write
//   o_illegal     illegal-instruction flag, held until reset
//   o_state       current state code
module main_fsm (
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic [6:0] i_op,
  input  logic       i_mem_done,
  output logic [2:0] o_alu_op,
  output logic [1:0] o_alu_src_1,
  output logic [1:0] o_alu_src_2,
  output logic [1:0] o_result_src,
  output logic       o_addr_src,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_instr_we,
  output logic       o_pc_update,
  output logic       o_branch,
  output logic       o_reg_we,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [2:0]  exec_alu_op_s;
  logic [2:0]  alu_op_s;
  logic [1:0]  alu_src_1_s;
  logic [1:0]  alu_src_2_s;
  logic [1:0]  result_src_s;
  logic        addr_src_s;
  logic        mem_req_s;
  logic        mem_we_s;
  logic        instr_we_s;
  logic        pc_update_s;
  logic        branch_s;
  logic        reg_we_s;
  logic        illegal_s;
  logic [3:0]  state_out_s;

  // ALU class for EXECR/EXECI: W-type when opcode bit 3 is set and W ops exist.
  always_comb begin
`ifdef RV64_W_EN
    if (i_op[3]) begin
      exec_alu_op_s = 3'b011;
    end else begin
      exec_alu_op_s = 3'b010;
    end
`else
    exec_alu_op_s = 3'b010;
`endif
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and output decode; everything is held at 0 while in reset.
  always_comb begin
    state_next_s = S_FETCH;
    alu_op_s     = 3'b000;
    alu_src_1_s  = 2'b00;
    alu_src_2_s  = 2'b00;
    result_src_s = 2'b00;
    addr_src_s   = 1'b0;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    instr_we_s   = 1'b0;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    reg_we_s     = 1'b0;
    illegal_s    = 1'b0;
    state_out_s  = 4'd0;
    if (i_arst_n) begin
      state_out_s = state_r;
      case (state_r)
        S_FETCH: begin
          mem_req_s = 1'b1;
          if (i_mem_done) begin
            instr_we_s   = 1'b1;
            pc_update_s  = 1'b1;
            alu_src_2_s  = 2'b10;
            result_src_s = 2'b10;
            state_next_s = S_DECODE;
          end else begin
            state_next_s = S_FETCH;
          end
        end
        S_DECODE: begin
          // Precompute PC + imm into ALUOut for branch/JAL targets.
          alu_src_1_s = 2'b01;
          alu_src_2_s = 2'b01;
          case (i_op)
            7'b0000011: state_next_s = S_MEMADDR;
            7'b0100011: state_next_s = S_MEMADDR;
            7'b0110011: state_next_s = S_EXECR;
            7'b0010011: state_next_s = S_EXECI;
            7'b1100011: state_next_s = S_BRANCH;
            7'b1101111: state_next_s = S_JAL;
            7'b1100111: state_next_s = S_JALR;
            7'b0110111: state_next_s = S_LUI;
            7'b0010111: state_next_s = S_AUIPC;
            7'b0001111: state_next_s = S_FETCH;
`ifdef RV64_W_EN
            7'b0111011: state_next_s = S_EXECR;
            7'b0011011: state_next_s = S_EXECI;
`endif
            default:    state_next_s = S_TRAP;
          endcase
        end
        S_MEMADDR: begin
          alu_src_1_s = 2'b10;
          alu_src_2_s = 2'b01;
          if (i_op[5]) begin
            state_next_s = S_MEMWRITE;
          end else begin
            state_next_s = S_MEMREAD;
          end
        end
        S_MEMREAD: begin
          mem_req_s  = 1'b1;
          addr_src_s = 1'b1;
          if (i_mem_done) begin
            state_next_s = S_MEMWB;
          end else begin
            state_next_s = S_MEMREAD;
          end
        end
        S_MEMWB: begin
          result_src_s = 2'b01;
          reg_we_s     = 1'b1;
          state_next_s = S_FETCH;
        end
        S_MEMWRITE: begin
          mem_req_s  = 1'b1;
          mem_we_s   = 1'b1;
          addr_src_s = 1'b1;
          if (i_mem_done) begin
            state_next_s = S_FETCH;
          end else begin
            state_next_s = S_MEMWRITE;
          end
        end
        S_EXECR: begin
          alu_src_1_s  = 2'b10;
          alu_op_s     = exec_alu_op_s;
          state_next_s = S_ALUWB;
        end
        S_EXECI: begin
          alu_src_1_s  = 2'b10;
          alu_src_2_s  = 2'b01;
          alu_op_s     = exec_alu_op_s;
          state_next_s = S_ALUWB;
        end
        S_ALUWB: begin
          reg_we_s     = 1'b1;
          state_next_s = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_1_s  = 2'b10;
          alu_op_s     = 3'b001;
          branch_s     = 1'b1;
          state_next_s = S_FETCH;
        end
        S_JAL: begin
          // PC <- ALUOut (target) while the ALU forms the link address.
          pc_update_s  = 1'b1;
          alu_src_1_s  = 2'b01;
          alu_src_2_s  = 2'b10;
          state_next_s = S_ALUWB;
        end
        S_JALR: begin
          alu_src_1_s  = 2'b10;
          alu_src_2_s  = 2'b01;
          state_next_s = S_JAL;
        end
        S_LUI: begin
          result_src_s = 2'b11;
          reg_we_s     = 1'b1;
          state_next_s = S_FETCH;
        end
        S_AUIPC: begin
          alu_src_1_s  = 2'b01;
          alu_src_2_s  = 2'b01;
          state_next_s = S_ALUWB;
        end
        S_TRAP: begin
          illegal_s    = 1'b1;
          state_next_s = S_TRAP;
        end
        default: begin
          // Unused code 15 recovers to FETCH.
          state_next_s = S_FETCH;
        end
      endcase
    end else begin
      state_next_s = S_FETCH;
    end
  end

  assign o_alu_op     = alu_op_s;
  assign o_alu_src_1  = alu_src_1_s;
  assign o_alu_src_2  = alu_src_2_s;
  assign o_result_src = result_src_s;
  assign o_addr_src   = addr_src_s;
  assign o_mem_req    = mem_req_s;
  assign o_mem_we     = mem_we_s;
  assign o_instr_we   = instr_we_s;
  assign o_pc_update  = pc_update_s;
  assign o_branch     = branch_s;
  assign o_reg_we     = reg_we_s;
  assign o_illegal    = illegal_s;
  assign o_state      = state_out_s;

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm. A reference model expands each
// instruction (opcode plus memory wait counts) into the expected per-cycle
// trace of state and outputs; the bench then drives the inputs of every
// cycle and compares every output on the falling edge.
module tb_main_fsm;

  logic       clk;
  logic       arst_n;
  logic [6:0] op;
  logic       mem_done;
  logic [2:0] alu_op;
  logic [1:0] src_1, src_2, result_src;
  logic       addr_src, mem_req, mem_we, instr_we, pc_update, branch, reg_we, illegal;
  logic [3:0] state;

  main_fsm dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_op(op), .i_mem_done(mem_done),
    .o_alu_op(alu_op), .o_alu_src_1(src_1), .o_alu_src_2(src_2),
    .o_result_src(result_src), .o_addr_src(addr_src), .o_mem_req(mem_req),
    .o_mem_we(mem_we), .o_instr_we(instr_we), .o_pc_update(pc_update),
    .o_branch(branch), .o_reg_we(reg_we), .o_illegal(illegal), .o_state(state)
  );

`ifdef RV64_W_EN
  localparam bit W_EN = 1'b1;
`else
  localparam bit W_EN = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rn;
    logic       md;
    logic [6:0] op;
    logic [3:0] st;
    logic       req, mwe, asrc, rwe, iwe, pcu, br, ill;
    logic [2:0] aop;
    logic [1:0] s1, s2, rs;
  } rec_t;

  rec_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic push(input logic rn, input logic md, input logic [6:0] o, input logic [3:0] st,
                      input logic req, input logic mwe, input logic asrc, input logic rwe,
                      input logic iwe, input logic pcu, input logic br, input logic ill,
                      input logic [2:0] aop, input logic [1:0] s1, input logic [1:0] s2,
                      input logic [1:0] rs);
    rec_t r;
    r.rn = rn; r.md = md; r.op = o; r.st = st;
    r.req = req; r.mwe = mwe; r.asrc = asrc; r.rwe = rwe;
    r.iwe = iwe; r.pcu = pcu; r.br = br; r.ill = ill;
    r.aop = aop; r.s1 = s1; r.s2 = s2; r.rs = rs;
    q.push_back(r);
  endtask

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  // One reset cycle: every output is expected to be 0.
  task automatic add_reset(input logic md);
    push(1'b0, md, 7'($urandom), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         3'd0, 2'd0, 2'd0, 2'd0);
  endtask

  // Expected trace of one complete instruction, from its fetch onward.
  // A trap is held for tn cycles and then cleared by a two-cycle reset pulse.
  task automatic add_instr(input logic [6:0] o, input int wf, input int wm, input int tn);
    logic       is_w;
    logic [2:0] xop;
    is_w = W_EN && (o == 7'b0111011 || o == 7'b0011011);
    xop  = is_w ? 3'b011 : 3'b010;
    for (int i = 0; i < wf; i++)
      push(1'b1, 1'b0, o, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0);
    push(1'b1, 1'b1, o, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 2'd2, 2'd2);
    push(1'b1, rnd_bit(), o, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd1, 2'd1, 2'd0);
    if (o == 7'b0000011 || o == 7'b0100011)
      push(1'b1, rnd_bit(), o, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 2'd1, 2'd0);
    case (o)
      7'b0000011: begin
        for (int i = 0; i <= wm; i++)
          push(1'b1, logic'(i == wm), o, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0);
        push(1'b1, rnd_bit(), o, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd1);
      end
      7'b0100011: begin
        for (int i = 0; i <= wm; i++)
          push(1'b1, logic'(i == wm), o, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0);
      end
      7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011: begin
        if (o[4] == 1'b1 && o != 7'b0111011 && o != 7'b0011011 || is_w) begin
          if (o[5])
            push(1'b1, rnd_bit(), o, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, xop, 2'd2, 2'd0, 2'd0);
          else
            push(1'b1, rnd_bit(), o, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, xop, 2'd2, 2'd1, 2'd0);
          push(1'b1, rnd_bit(), o, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0);
        end else begin
          for (int i = 0; i < tn; i++)
            push(1'b1, rnd_bit(), o, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 2'd0, 2'd0);
          add_reset(rnd_bit());
          add_reset(rnd_bit());
        end
      end
      7'b1100011:
        push(1'b1, rnd_bit(), o, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 2'd2, 2'd0, 2'd0);
      7'b1101111, 7'b1100111: begin
        if (o[3] == 1'b0)
          push(1'b1, rnd_bit(), o, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 2'd1, 2'd0);
        push(1'b1, rnd_bit(), o, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd1, 2'd2, 2'd0);
        push(1'b1, rnd_bit(), o, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0);
      end
      7'b0110111:
        push(1'b1, rnd_bit(), o, 4'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd3);
      7'b0010111: begin
        push(1'b1, rnd_bit(), o, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd1, 2'd1, 2'd0);
        push(1'b1, rnd_bit(), o, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0);
      end
      7'b0001111: ;
      default: begin
        for (int i = 0; i < tn; i++)
          push(1'b1, rnd_bit(), o, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 2'd0, 2'd0);
        add_reset(rnd_bit());
        add_reset(rnd_bit());
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Drive every queued cycle and compare all outputs at the falling edge.
  task automatic run_queue();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      arst_n   = r.rn;
      mem_done = r.md;
      op       = r.op;
      @(negedge clk);
      chk("state",      state,               r.st);
      chk("mem_req",    4'(mem_req),         4'(r.req));
      chk("mem_we",     4'(mem_we),          4'(r.mwe));
      chk("addr_src",   4'(addr_src),        4'(r.asrc));
      chk("reg_we",     4'(reg_we),          4'(r.rwe));
      chk("instr_we",   4'(instr_we),        4'(r.iwe));
      chk("pc_update",  4'(pc_update),       4'(r.pcu));
      chk("branch",     4'(branch),          4'(r.br));
      chk("illegal",    4'(illegal),         4'(r.ill));
      chk("alu_op",     4'(alu_op),          4'(r.aop));
      chk("alu_src_1",  4'(src_1),           4'(r.s1));
      chk("alu_src_2",  4'(src_2),           4'(r.s2));
      chk("result_src", 4'(result_src),      4'(r.rs));
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  logic [6:0] legal_ops [12];

  initial begin
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
                  7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b0111011, 7'b0011011};
    arst_n = 1'b0; mem_done = 1'b0; op = 7'd0;
    @(posedge clk);
    #1;
    // Reset, then directed scenarios.
    add_reset(1'b1);
    add_reset(1'b0);
    add_instr(7'b0110011, 0, 0, 0);   // add, zero wait
    add_instr(7'b0000011, 2, 2, 0);   // lw, two wait cycles in fetch and read
    add_instr(7'b1100111, 0, 0, 0);   // jalr
    add_instr(7'b0011011, 0, 0, 12);  // addiw
    add_instr(7'b1111111, 1, 0, 3);   // illegal opcode, then reset pulse
    add_instr(7'b0001111, 0, 0, 0);   // fence
    add_instr(7'b0100011, 1, 3, 0);   // store with waits
    // Store interrupted by reset in MEMWRITE with done low, then a late done.
    add_instr(7'b0110111, 0, 0, 0);
    push(1'b1, 1'b1, 7'b0100011, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 2'd2, 2'd2);
    push(1'b1, 1'b0, 7'b0100011, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd1, 2'd1, 2'd0);
    push(1'b1, 1'b0, 7'b0100011, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 2'd1, 2'd0);
    push(1'b1, 1'b0, 7'b0100011, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0);
    add_reset(1'b0);
    add_reset(1'b1);
    add_instr(7'b0100011, 1, 0, 0);   // fetch waits after release: state stays 0
    run_queue();
    // Randomised instruction stream.
    for (int n = 0; n < 60; n++) begin
      logic [6:0] o;
      if ($urandom_range(0, 4) == 0) o = 7'($urandom);
      else o = legal_ops[$urandom_range(0, 11)];
      add_instr(o, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(1, 4));
      run_queue();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
